// File: rtl/scale_pkg.sv
// Shared constants and state encoding for the grams-to-kilograms weighing path.
// Contents:
//   GRAMS_W, KG_INT_W, KG_FRAC_W  datapath widths
//   GRAMS_PER_KG                  divisor used by the sequential divider
//   state_t                       controller state encoding
package scale_pkg;

    localparam int GRAMS_W   = 12;
    localparam int KG_INT_W  = 12;
    localparam int KG_FRAC_W = 10;

    localparam logic [GRAMS_W-1:0] GRAMS_PER_KG = 12'd1000;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        PROCESS = 2'd1,
        CONVERT = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

endpackage

// File: rtl/grams_div1000_seq.sv
// Sequential divide-by-1000 by repeated subtraction.
// A start pulse loads net; afterwards one subtraction is done per cycle.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   start       load net and begin dividing (one-cycle pulse)
//   net         dividend in grams
//   done        high while the quotient/remainder are final and a division is running
//   q           quotient in kilograms (held after done)
//   rem         remainder in grams, 0..999 (held after done)
module grams_div1000_seq
    import scale_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [GRAMS_W-1:0]   net,
    output logic                 done,
    output logic [KG_INT_W-1:0]  q,
    output logic [KG_FRAC_W-1:0] rem
);

    logic                running;
    logic [GRAMS_W-1:0]  rem_r;
    logic [KG_INT_W-1:0] q_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            rem_r   <= '0;
            q_r     <= '0;
        end else if (start) begin
            running <= 1'b1;
            rem_r   <= net;
            q_r     <= '0;
        end else if (running) begin
            if (rem_r >= GRAMS_PER_KG) begin
                rem_r <= rem_r - GRAMS_PER_KG;
                q_r   <= q_r + 12'd1;
            end else begin
                running <= 1'b0;
            end
        end
    end

    // done is flagged in the cycle the remainder first drops below 1000,
    // so the caller can leave its wait state on the same edge that stops us.
    assign done = running && (rem_r < GRAMS_PER_KG);
    assign q    = q_r;
    assign rem  = rem_r[KG_FRAC_W-1:0];

endmodule

// File: rtl/scale_weigh_controller.sv
// Weighing-scale controller: averages raw gram samples over a window, applies
// tare, tracks stability and overload, and converts net grams to kg + grams.
//
//   state   | meaning
//   ACCUM   | summing samples of the current window
//   PROCESS | one cycle: tare, net, overload, stability update, start divide
//   CONVERT | waiting on the sequential divide-by-1000
//   OUTPUT  | one cycle: update display registers, pulse displayValid
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   sampleValid/Grams    raw gross weight sample (ignored unless in ACCUM)
//   tareReq              tare request, latched until the next PROCESS
//   kgInteger/kgFraction net weight as whole kg and remaining grams
//   displayValid         one-cycle pulse per processed window
//   stable, overload     registered status levels, updated in PROCESS
//   busy                 high whenever samples are not accepted
module scale_weigh_controller
    import scale_pkg::*;
#(
    parameter int AVG_LOG2     = 2,
    parameter int STABLE_TOL   = 5,
    parameter int STABLE_COUNT = 3,
    parameter int MAX_GRAMS    = 4000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sampleValid,
    input  logic [GRAMS_W-1:0]   sampleGrams,
    input  logic                 tareReq,
    output logic [KG_INT_W-1:0]  kgInteger,
    output logic [KG_FRAC_W-1:0] kgFraction,
    output logic                 displayValid,
    output logic                 stable,
    output logic                 overload,
    output logic                 busy
);

    localparam int ACC_W = GRAMS_W + AVG_LOG2;
    localparam int SC_W  = $clog2(STABLE_COUNT + 1);

    state_t               state;
    logic [ACC_W-1:0]     acc;
    logic [AVG_LOG2-1:0]  cnt;
    logic [GRAMS_W-1:0]   avg;
    logic [GRAMS_W-1:0]   prev_avg;
    logic [GRAMS_W-1:0]   tare_offset;
    logic                 tare_pending;
    logic [SC_W-1:0]      stable_cnt;

    logic [ACC_W-1:0]     acc_sum;
    logic [GRAMS_W-1:0]   diff;
    logic [GRAMS_W-1:0]   net;
    logic [SC_W-1:0]      stable_cnt_next;

    logic                 div_done;
    logic [KG_INT_W-1:0]  div_q;
    logic [KG_FRAC_W-1:0] div_rem;

    always_comb begin
        acc_sum = acc + {{AVG_LOG2{1'b0}}, sampleGrams};
        diff    = (avg >= prev_avg) ? (avg - prev_avg) : (prev_avg - avg);

        stable_cnt_next = '0;
        if (diff <= GRAMS_W'(STABLE_TOL)) begin
            if (stable_cnt >= SC_W'(STABLE_COUNT))
                stable_cnt_next = stable_cnt;
            else
                stable_cnt_next = stable_cnt + SC_W'(1);
        end

        net = '0;
        if (!tare_pending && (avg > tare_offset))
            net = avg - tare_offset;
    end

    grams_div1000_seq u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (state == PROCESS),
        .net   (net),
        .done  (div_done),
        .q     (div_q),
        .rem   (div_rem)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ACCUM;
            acc          <= '0;
            cnt          <= '0;
            avg          <= '0;
            prev_avg     <= '0;
            tare_offset  <= '0;
            tare_pending <= 1'b0;
            stable_cnt   <= '0;
            kgInteger    <= '0;
            kgFraction   <= '0;
            displayValid <= 1'b0;
            stable       <= 1'b0;
            overload     <= 1'b0;
        end else begin
            displayValid <= 1'b0;
            if (tareReq)
                tare_pending <= 1'b1;

            case (state)
                ACCUM: begin
                    if (sampleValid) begin
                        if (cnt == '1) begin
                            avg   <= acc_sum[ACC_W-1 -: GRAMS_W];
                            acc   <= '0;
                            cnt   <= '0;
                            state <= PROCESS;
                        end else begin
                            acc <= acc_sum;
                            cnt <= cnt + AVG_LOG2'(1);
                        end
                    end
                end
                PROCESS: begin
                    overload <= (avg > GRAMS_W'(MAX_GRAMS));
                    if (tare_pending) begin
                        tare_offset  <= avg;
                        // A request arriving in this very cycle stays pending.
                        tare_pending <= tareReq;
                    end
                    stable_cnt <= stable_cnt_next;
                    stable     <= (stable_cnt_next >= SC_W'(STABLE_COUNT));
                    prev_avg   <= avg;
                    state      <= CONVERT;
                end
                CONVERT: begin
                    if (div_done)
                        state <= OUTPUT;
                end
                OUTPUT: begin
                    if (!overload) begin
                        kgInteger  <= div_q;
                        kgFraction <= div_rem;
                    end
                    displayValid <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                    state        <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign busy = (state != ACCUM);

endmodule

// File: tb/tb_scale_weigh_controller.sv
module tb_scale_weigh_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sampleValid;
    logic [11:0] sampleGrams;
    logic        tareReq;
    logic [11:0] kgInteger;
    logic [9:0]  kgFraction;
    logic        displayValid;
    logic        stable;
    logic        overload;
    logic        busy;

    scale_weigh_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sampleValid  (sampleValid),
        .sampleGrams  (sampleGrams),
        .tareReq      (tareReq),
        .kgInteger    (kgInteger),
        .kgFraction   (kgFraction),
        .displayValid (displayValid),
        .stable       (stable),
        .overload     (overload),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kgi;
        int kgf;
        int ovl;
        int stb;
        int at;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (spec-level quantities only)
    int m_tare, m_prev, m_steady, m_kgi, m_kgf;
    bit m_pend;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_tare = 0; m_prev = 0; m_steady = 0; m_kgi = 0; m_kgf = 0; m_pend = 0;
        exp_q.delete();
    endtask

    // Predict the display for one window whose last sample is accepted at cycle t_last
    task automatic model_window(input int s[4], input int t_last);
        int avg, net, d;
        exp_t e;
        avg = (s[0] + s[1] + s[2] + s[3]) / 4;
        e.ovl = (avg > 4000) ? 1 : 0;
        if (m_pend) begin
            m_tare = avg;
            net    = 0;
            m_pend = 0;
        end else begin
            net = (avg > m_tare) ? avg - m_tare : 0;
        end
        d = (avg > m_prev) ? avg - m_prev : m_prev - avg;
        if (d <= 5) m_steady = (m_steady < 3) ? m_steady + 1 : 3;
        else        m_steady = 0;
        e.stb  = (m_steady >= 3) ? 1 : 0;
        m_prev = avg;
        if (e.ovl == 0) begin
            m_kgi = net / 1000;
            m_kgf = net % 1000;
        end
        e.kgi = m_kgi;
        e.kgf = m_kgf;
        e.at  = t_last + 3 + net / 1000;
        exp_q.push_back(e);
    endtask

    // Called just after a rising edge. Drives one window; optionally waits for idle.
    task automatic send_window(input int s[4], input bit gaps, input bit wait_idle);
        int c_last;
        bit idle;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sampleValid = 1'b0;
                    sampleGrams = 12'($urandom_range(0, 4095));
                    @(posedge clk); #1;
                end
            end
            sampleValid = 1'b1;
            sampleGrams = 12'(s[i]);
            c_last = cyc + 1;
            @(posedge clk); #1;
        end
        sampleValid = 1'b0;
        model_window(s, c_last);
        if (wait_idle) begin
            idle = 1'b0;
            for (int n = 0; n < 40; n++) begin
                if (!busy) begin
                    idle = 1'b1;
                    break;
                end
                sampleValid = 1'($urandom_range(0, 1));
                sampleGrams = 12'($urandom_range(0, 4095));
                @(posedge clk); #1;
            end
            sampleValid = 1'b0;
            if (!idle) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_timeout: busy still %0d after 40 cycles", busy);
            end
        end
    endtask

    task automatic send_const(input int v);
        int s[4];
        for (int i = 0; i < 4; i++) s[i] = v;
        send_window(s, 1'b0, 1'b1);
    endtask

    task automatic send_four(input int a, input int b, input int c, input int d);
        int s[4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        send_window(s, 1'b0, 1'b1);
    endtask

    task automatic do_tare(input bit twice);
        tareReq = 1'b1;
        @(posedge clk); #1;
        tareReq = 1'b0;
        if (twice) begin
            @(posedge clk); #1;
            tareReq = 1'b1;
            @(posedge clk); #1;
            tareReq = 1'b0;
        end
        m_pend = 1'b1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_kgInteger"},    int'(kgInteger), 0);
        chk({tag, "_kgFraction"},   int'(kgFraction), 0);
        chk({tag, "_displayValid"}, int'(displayValid), 0);
        chk({tag, "_stable"},       int'(stable), 0);
        chk({tag, "_overload"},     int'(overload), 0);
        chk({tag, "_busy"},         int'(busy), 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && displayValid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_display: kg=%0d frac=%0d with nothing expected",
                         kgInteger, kgFraction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("kgInteger",  int'(kgInteger),  e.kgi);
                chk("kgFraction", int'(kgFraction), e.kgf);
                chk("overload",   int'(overload),   e.ovl);
                chk("stable",     int'(stable),     e.stb);
                chk("latency",    cyc,              e.at);
            end
        end
    end

    initial begin
        int s[4];
        int base;
        rst_n       = 1'b0;
        sampleValid = 1'b0;
        sampleGrams = '0;
        tareReq     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_cleared("reset");

        // Basic conversions
        send_const(2000);
        send_four(1000, 1001, 1002, 1003);

        // Tare, then above and below the tare point
        do_tare(1'b0);
        send_const(500);
        send_const(1500);
        send_const(300);

        // Re-tare to zero (double request collapses), then overload hold
        do_tare(1'b1);
        send_const(0);
        send_const(2000);
        send_const(4050);
        send_const(2000);

        // Stability sequence
        send_const(2000);
        send_const(2002);
        send_const(1998);
        send_const(2001);
        send_const(2100);

        // Reset mid-CONVERT with a non-zero tare in place
        do_tare(1'b0);
        send_const(1000);
        for (int i = 0; i < 4; i++) s[i] = 3000;
        send_window(s, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        check_cleared("midconv_reset");
        repeat (10) @(posedge clk);
        #1;
        send_const(3000);

        // Randomized windows with gaps, dropped samples and occasional tare
        for (int w = 0; w < 30; w++) begin
            if ($urandom_range(0, 5) == 0) do_tare(1'($urandom_range(0, 1)));
            base = $urandom_range(0, 4095);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    s[i] = base + $urandom_range(0, 6) - 3;
                    if (s[i] < 0) s[i] = 0;
                    if (s[i] > 4095) s[i] = 4095;
                end else begin
                    s[i] = $urandom_range(0, 4095);
                end
            end
            send_window(s, 1'b1, 1'b1);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
